// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner_pkg
//  Description : Shared types, idle levels and width helpers for the board
//                button/slider input conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_conditioner_pkg;

    // Level each output holds while released/idle and after reset.
    localparam logic BTN_IDLE = 1'b1;   // KEY pins are active-low
    localparam logic SW_IDLE  = 1'b0;

    // Per-bit debounce state.
    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    // Bits needed for a 0..div-1 prescaler.
    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

    // Bits needed to hold 0..ticks so the tick counter can never wrap.
    function automatic int cnt_width(input int ticks);
        return (ticks < 1) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : Debounces one synchronised input bit. A change is accepted
//                only after it has persisted for DEBOUNCE_TICKS prescaler
//                ticks; any return to the committed level restarts it.
//                Emits one-cycle rise/fall pulses aligned with the new level.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter logic RESET_LEVEL    = 1'b0,
    parameter int   DEBOUNCE_TICKS = 10
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic din_sync,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             C_CNT_W = cnt_width(DEBOUNCE_TICKS);
    // Count value at which the next tick completes the window.
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_TICKS - 1);

    db_state_e            state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 w_differ;
    logic                 w_commit;

    assign w_differ = (din_sync != level_q);

    // State, counter, committed level and event pulses.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: enter PENDING on a difference, count ticks, commit on the last one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_commit = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (w_differ) begin
                    state_d = ST_PENDING;
                    cnt_d   = '0;
                end
            end
            ST_PENDING: begin
                if (!w_differ) begin
                    // Glitch: input came back before the window completed.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == C_CNT_LAST) begin
                        w_commit = 1'b1;
                        state_d  = ST_STABLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + C_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: the commit updates the level and fires the matching edge pulse together.
    always_comb begin
        level_d = w_commit ? din_sync : level_q;
        rise_d  = w_commit &  din_sync;
        fall_d  = w_commit & ~din_sync;
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : Synchronises and debounces board KEY/SW pins ahead of the
//                SOPC PIO inputs; produces press/release and slider-change
//                event pulses. One shared prescaler paces all bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NUM_BUTTONS    = 2,
    parameter int NUM_SLIDERS    = 10,
    parameter int TICK_DIV       = 50000,  // >= 2
    parameter int DEBOUNCE_TICKS = 10      // >= 1
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [NUM_BUTTONS-1:0] key_n_raw,
    input  logic [NUM_SLIDERS-1:0] sw_raw,
    output logic [NUM_BUTTONS-1:0] push_button_export,
    output logic [NUM_SLIDERS-1:0] sliders_export,
    output logic [NUM_BUTTONS-1:0] button_press,
    output logic [NUM_BUTTONS-1:0] button_release,
    output logic                   slider_change
);

    localparam int                   C_PRESC_W    = presc_width(TICK_DIV);
    localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(TICK_DIV - 1);

    logic [NUM_BUTTONS-1:0] key_meta_q, key_sync_q;
    logic [NUM_SLIDERS-1:0] sw_meta_q, sw_sync_q;
    logic [C_PRESC_W-1:0]   presc_q, presc_d;
    logic                   w_tick;
    logic [NUM_SLIDERS-1:0] w_sw_rise, w_sw_fall;

    // Two-flop synchronisers; reset to the idle level so no event follows reset.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            key_meta_q <= {NUM_BUTTONS{BTN_IDLE}};
            key_sync_q <= {NUM_BUTTONS{BTN_IDLE}};
            sw_meta_q  <= {NUM_SLIDERS{SW_IDLE}};
            sw_sync_q  <= {NUM_SLIDERS{SW_IDLE}};
        end else begin
            key_meta_q <= key_n_raw;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= sw_raw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Free-running prescaler shared by every bit; tick on the last count.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign w_tick = (presc_q == C_PRESC_LAST);

    // Prescaler next count: wrap to zero right after the tick.
    always_comb begin
        presc_d = w_tick ? '0 : presc_q + C_PRESC_W'(1);
    end

    generate
        for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
            // Active-low button: 1->0 is a press, 0->1 a release.
            debounce_bit #(
                .RESET_LEVEL    (BTN_IDLE),
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
            ) u_db (
                .clk_clk     (clk_clk),
                .reset_reset (reset_reset),
                .din_sync    (key_sync_q[i]),
                .tick        (w_tick),
                .level       (push_button_export[i]),
                .rise        (button_release[i]),
                .fall        (button_press[i])
            );
        end

        for (genvar j = 0; j < NUM_SLIDERS; j++) begin : g_sw
            debounce_bit #(
                .RESET_LEVEL    (SW_IDLE),
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
            ) u_db (
                .clk_clk     (clk_clk),
                .reset_reset (reset_reset),
                .din_sync    (sw_sync_q[j]),
                .tick        (w_tick),
                .level       (sliders_export[j]),
                .rise        (w_sw_rise[j]),
                .fall        (w_sw_fall[j])
            );
        end
    endgenerate

    // Commits landing in the same cycle collapse into a single pulse.
    assign slider_change = |(w_sw_rise | w_sw_fall);

endmodule
`default_nettype wire
